id_ex_stage: RTL and testbench



---
 rtl/id_ex_stage.sv | 202 ++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register feeding the ALU. It captures the decoded instruction
// fields and resolves operand forwarding from the EX/MEM and MEM/WB stages. It
// also detects load-use hazards and turns the following slot into a bubble.
//
// Optional feature macro: FWD_EN
//   defined   : ALU operands and store data are forwarded from EX/MEM and MEM/WB
//   undefined : operands come straight from the registered read data; the
//               exm_* and wb_* ports are ignored
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   stall, flush          hold all contents / load a bubble
//   id_*                  decoded instruction fields from the decode stage
//   exm_*, wb_*           forwarding sources (write enable, index, result)
//   alu_a, alu_b          ALU operands
//   alu_control           ALU opcode
//   shift_amount          ALU shift amount
//   store_data            forwarded rt value for stores
//   ex_write_reg          destination register index
//   ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg
//                         registered control bits toward EX/MEM
//   load_use_stall        upstream must hold PC and IF/ID
// -----------------------------------------------------------------------------
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [15:0] id_imm,
    input  logic        id_imm_zero_ext,
    input  logic [4:0]  id_shamt,
    input  logic [3:0]  id_alu_control,
    input  logic        id_alu_src,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        id_uses_rt,
    input  logic        id_reg_dst,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        id_mem_to_reg,
    input  logic        exm_reg_write,
    input  logic [4:0]  exm_rd,
    input  logic [31:0] exm_result,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_result,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_control,
    output logic [4:0]  shift_amount,
    output logic [31:0] store_data,
    output logic [4:0]  ex_write_reg,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_mem_to_reg,
    output logic        load_use_stall
);

    // All-zero value of this record is the bubble (add 0+0, no side effects).
    typedef struct packed {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] ext_imm;
        logic [4:0]  shamt;
        logic [3:0]  alu_control;
        logic        alu_src;
        logic [4:0]  write_reg;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
    } ex_regs_t;

    ex_regs_t    ex_r;
    ex_regs_t    capture_s;
    logic        load_use_s;
    logic [31:0] fwd_rs_s;
    logic [31:0] fwd_rt_s;

`ifdef FWD_EN
    // EX/MEM has priority over MEM/WB; register 0 is never forwarded.
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  idx,
        input logic [31:0] reg_data,
        input logic        e_we,
        input logic [4:0]  e_rd,
        input logic [31:0] e_res,
        input logic        w_we,
        input logic [4:0]  w_rd,
        input logic [31:0] w_res
    );
        logic [31:0] sel;
        if (e_we && (e_rd != 5'd0) && (e_rd == idx)) begin
            sel = e_res;
        end else if (w_we && (w_rd != 5'd0) && (w_rd == idx)) begin
            sel = w_res;
        end else begin
            sel = reg_data;
        end
        return sel;
    endfunction

    // Forwarding muxes on the registered source indices.
    always_comb begin
        fwd_rs_s = fwd_sel(ex_r.rs, ex_r.rs_data, exm_reg_write, exm_rd, exm_result,
                           wb_reg_write, wb_rd, wb_result);
        fwd_rt_s = fwd_sel(ex_r.rt, ex_r.rt_data, exm_reg_write, exm_rd, exm_result,
                           wb_reg_write, wb_rd, wb_result);
    end
`else
    // Without forwarding the later-stage ports and source indices are unused.
    logic unused_fwd_s;
    assign unused_fwd_s = ^{exm_reg_write, exm_rd, exm_result,
                            wb_reg_write, wb_rd, wb_result, ex_r.rs, ex_r.rt};

    // Operands come straight from the registered read data.
    always_comb begin
        fwd_rs_s = ex_r.rs_data;
        fwd_rt_s = ex_r.rt_data;
    end
`endif

    // Load in EX whose destination is read by the instruction in decode.
    always_comb begin
        load_use_s = 1'b0;
        if (ex_r.valid && ex_r.mem_read && (ex_r.write_reg != 5'd0)) begin
            load_use_s = (ex_r.write_reg == id_rs) ||
                         (id_uses_rt && (ex_r.write_reg == id_rt));
        end else begin
            load_use_s = 1'b0;
        end
    end

    // Next register contents when a decode instruction is accepted.
    always_comb begin
        capture_s             = '0;
        capture_s.valid       = id_valid;
        capture_s.rs          = id_rs;
        capture_s.rt          = id_rt;
        capture_s.rs_data     = id_rs_data;
        capture_s.rt_data     = id_rt_data;
        if (id_imm_zero_ext) begin
            capture_s.ext_imm = {16'h0000, id_imm};
        end else begin
            capture_s.ext_imm = {{16{id_imm[15]}}, id_imm};
        end
        capture_s.shamt       = id_shamt;
        capture_s.alu_control = id_alu_control;
        capture_s.alu_src     = id_alu_src;
        if (id_reg_dst) begin
            capture_s.write_reg = id_rd;
        end else begin
            capture_s.write_reg = id_rt;
        end
        capture_s.reg_write   = id_reg_write;
        capture_s.mem_read    = id_mem_read;
        capture_s.mem_write   = id_mem_write;
        capture_s.mem_to_reg  = id_mem_to_reg;
    end

    // Pipeline register: reset, flush, hold, hazard bubble, capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_r <= '0;
        end else if (flush) begin
            ex_r <= '0;
        end else if (stall) begin
            ex_r <= ex_r;
        end else if (load_use_s) begin
            ex_r <= '0;
        end else begin
            ex_r <= capture_s;
        end
    end

    assign alu_a          = fwd_rs_s;
    assign alu_b          = ex_r.alu_src ? ex_r.ext_imm : fwd_rt_s;
    assign store_data     = fwd_rt_s;
    assign alu_control    = ex_r.alu_control;
    assign shift_amount   = ex_r.shamt;
    assign ex_write_reg   = ex_r.write_reg;
    assign ex_valid       = ex_r.valid;
    assign ex_reg_write   = ex_r.reg_write;
    assign ex_mem_read    = ex_r.mem_read;
    assign ex_mem_write   = ex_r.mem_write;
    assign ex_mem_to_reg  = ex_r.mem_to_reg;
    assign load_use_stall = load_use_s;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed bench for id_ex_stage. The driver applies inputs just after each
// rising edge and queues the values the outputs must show at the following
// falling edge; a separate monitor pops and compares them on every falling
// edge. Forwarding expectations follow the FWD_EN build option.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush;
    logic        id_valid;
    logic [31:0] id_rs_data, id_rt_data;
    logic [15:0] id_imm;
    logic        id_imm_zero_ext;
    logic [4:0]  id_shamt;
    logic [3:0]  id_alu_control;
    logic        id_alu_src;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_uses_rt, id_reg_dst;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        exm_reg_write;
    logic [4:0]  exm_rd;
    logic [31:0] exm_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic [31:0] alu_a, alu_b, store_data;
    logic [3:0]  alu_control;
    logic [4:0]  shift_amount, ex_write_reg;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic        load_use_stall;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_imm_zero_ext(id_imm_zero_ext), .id_shamt(id_shamt),
        .id_alu_control(id_alu_control), .id_alu_src(id_alu_src),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .shift_amount(shift_amount), .store_data(store_data),
        .ex_write_reg(ex_write_reg), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .load_use_stall(load_use_stall)
    );

    always #5 clk = ~clk;

    localparam int S_ALU_A = 0, S_ALU_B = 1, S_CTRL = 2, S_SHAMT = 3, S_STORE = 4,
                   S_WREG = 5, S_VALID = 6, S_RW = 7, S_MR = 8, S_MW = 9,
                   S_M2R = 10, S_LUS = 11;

    typedef struct {
        string       name;
        int          sig;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic driver_done = 1'b0;

    function automatic logic [31:0] pick(input int sig);
        logic [31:0] v;
        case (sig)
            S_ALU_A: v = alu_a;
            S_ALU_B: v = alu_b;
            S_CTRL:  v = {28'd0, alu_control};
            S_SHAMT: v = {27'd0, shift_amount};
            S_STORE: v = store_data;
            S_WREG:  v = {27'd0, ex_write_reg};
            S_VALID: v = {31'd0, ex_valid};
            S_RW:    v = {31'd0, ex_reg_write};
            S_MR:    v = {31'd0, ex_mem_read};
            S_MW:    v = {31'd0, ex_mem_write};
            S_M2R:   v = {31'd0, ex_mem_to_reg};
            S_LUS:   v = {31'd0, load_use_stall};
            default: v = 32'hxxxx_xxxx;
        endcase
        return v;
    endfunction

    // Monitor: compare every queued expectation at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                exp_t e;
                logic [31:0] act;
                e = sb.pop_front();
                act = pick(e.sig);
                n_checks++;
                if (act !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h, expected %h", e.name, act, e.val);
                end
            end
        end
    end

    task automatic push(input string nm, input int sig, input logic [31:0] v);
        exp_t e;
        e.name = nm;
        e.sig  = sig;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        stall = 1'b0; flush = 1'b0;
        id_valid = 1'b0; id_rs_data = 32'd0; id_rt_data = 32'd0;
        id_imm = 16'd0; id_imm_zero_ext = 1'b0; id_shamt = 5'd0;
        id_alu_control = 4'd0; id_alu_src = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
        id_uses_rt = 1'b0; id_reg_dst = 1'b0;
        id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
        id_mem_to_reg = 1'b0;
        exm_reg_write = 1'b0; exm_rd = 5'd0; exm_result = 32'd0;
        wb_reg_write = 1'b0; wb_rd = 5'd0; wb_result = 32'd0;
    endtask

    // Load in decode: lw into r8.
    task automatic set_load8();
        clear_id();
        id_valid = 1'b1; id_mem_read = 1'b1; id_reg_write = 1'b1;
        id_mem_to_reg = 1'b1; id_rt = 5'd8; id_reg_dst = 1'b0;
        id_alu_src = 1'b1; id_imm = 16'd4;
    endtask

    // Driver: directed vectors.
    initial begin
        logic fwd;
`ifdef FWD_EN
        fwd = 1'b1;
`else
        fwd = 1'b0;
`endif
        clear_id();
        rst_n = 1'b0;
        id_valid = 1'b1; id_alu_control = 4'h3; id_rd = 5'd7; id_reg_dst = 1'b1;
        id_rs_data = 32'h0000_1234; id_reg_write = 1'b1;
        tick(); tick();
        push("rst_valid", S_VALID, 32'd0);
        push("rst_alu_a", S_ALU_A, 32'd0);
        push("rst_alu_b", S_ALU_B, 32'd0);
        push("rst_ctrl",  S_CTRL,  32'd0);
        push("rst_wreg",  S_WREG,  32'd0);
        push("rst_store", S_STORE, 32'd0);
        push("rst_rw",    S_RW,    32'd0);
        push("rst_lus",   S_LUS,   32'd0);
        rst_n = 1'b1;
        tick();
        push("rel_valid", S_VALID, 32'd1);
        push("rel_ctrl",  S_CTRL,  32'd3);
        push("rel_wreg",  S_WREG,  32'd7);
        push("rel_alu_a", S_ALU_A, 32'h0000_1234);
        push("rel_rw",    S_RW,    32'd1);

        // Immediate extension.
        clear_id();
        id_valid = 1'b1; id_imm = 16'h8000; id_alu_src = 1'b1;
        id_rt = 5'd3; id_rt_data = 32'h0000_DEAD;
        tick();
        push("imm_sext",    S_ALU_B, 32'hFFFF_8000);
        push("imm_store",   S_STORE, 32'h0000_DEAD);
        push("imm_wreg_rt", S_WREG,  32'd3);
        id_imm_zero_ext = 1'b1;
        tick();
        push("imm_zext", S_ALU_B, 32'h0000_8000);

        // Forwarding priority.
        clear_id();
        id_valid = 1'b1; id_rs = 5'd5; id_rs_data = 32'h55;
        id_rt = 5'd5; id_rt_data = 32'h77;
        tick();
        exm_reg_write = 1'b1; exm_rd = 5'd5; exm_result = 32'h11;
        wb_reg_write = 1'b1;  wb_rd = 5'd5;  wb_result = 32'h22;
        push("fwd_exm_a",     S_ALU_A, fwd ? 32'h11 : 32'h55);
        push("fwd_exm_b",     S_ALU_B, fwd ? 32'h11 : 32'h77);
        push("fwd_exm_store", S_STORE, fwd ? 32'h11 : 32'h77);
        tick();
        exm_reg_write = 1'b0;
        push("fwd_wb_a",     S_ALU_A, fwd ? 32'h22 : 32'h55);
        push("fwd_wb_store", S_STORE, fwd ? 32'h22 : 32'h77);
        tick();
        exm_reg_write = 1'b1; exm_rd = 5'd0; wb_rd = 5'd0;
        id_rs = 5'd0; id_rs_data = 32'h66;
        tick();
        push("fwd_r0_a", S_ALU_A, 32'h66);

        // Load-use on rs: stall, then bubble.
        set_load8();
        tick();
        clear_id();
        id_valid = 1'b1; id_rs = 5'd8; id_alu_control = 4'h2;
        push("lu_rs_stall", S_LUS, 32'd1);
        push("lu_ex_mr",    S_MR,  32'd1);
        push("lu_ex_wreg",  S_WREG, 32'd8);
        tick();
        push("lu_bub_valid", S_VALID, 32'd0);
        push("lu_bub_ctrl",  S_CTRL,  32'd0);
        push("lu_bub_mr",    S_MR,    32'd0);
        push("lu_bub_lus",   S_LUS,   32'd0);
        tick();
        push("lu_after_valid", S_VALID, 32'd1);
        push("lu_after_ctrl",  S_CTRL,  32'd2);

        // Load-use on rt but rt unused: no stall.
        set_load8();
        tick();
        clear_id();
        id_valid = 1'b1; id_rt = 5'd8; id_uses_rt = 1'b0;
        push("lu_rt_unused", S_LUS, 32'd0);
        tick();
        push("lu_rt_unused_cap", S_VALID, 32'd1);

        // rt used, with stall: hold wins and the stall request persists.
        set_load8();
        tick();
        clear_id();
        id_valid = 1'b1; id_rt = 5'd8; id_uses_rt = 1'b1;
        push("lu_rt_used", S_LUS, 32'd1);
        stall = 1'b1;
        tick();
        push("lu_hold_lus",  S_LUS,  32'd1);
        push("lu_hold_mr",   S_MR,   32'd1);
        push("lu_hold_wreg", S_WREG, 32'd8);
        flush = 1'b1;
        tick();
        push("lu_flush_valid", S_VALID, 32'd0);
        push("lu_flush_mr",    S_MR,    32'd0);
        push("lu_flush_lus",   S_LUS,   32'd0);

        // Stall holds for three cycles despite new inputs.
        clear_id();
        id_valid = 1'b1; id_alu_control = 4'h9; id_shamt = 5'd17;
        id_rs_data = 32'hA5A5_A5A5; id_rd = 5'd12; id_reg_dst = 1'b1;
        id_reg_write = 1'b1; id_mem_write = 1'b1;
        tick();
        push("cap_ctrl",  S_CTRL,  32'd9);
        push("cap_shamt", S_SHAMT, 32'd17);
        push("cap_mw",    S_MW,    32'd1);
        stall = 1'b1;
        id_alu_control = 4'hF; id_shamt = 5'd3; id_rs_data = 32'd0;
        id_rd = 5'd1; id_mem_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            push("hold_ctrl",  S_CTRL,  32'd9);
            push("hold_shamt", S_SHAMT, 32'd17);
            push("hold_alu_a", S_ALU_A, 32'hA5A5_A5A5);
            push("hold_wreg",  S_WREG,  32'd12);
            push("hold_mw",    S_MW,    32'd1);
        end
        stall = 1'b0;
        tick();
        push("unhold_ctrl",  S_CTRL,  32'd15);
        push("unhold_shamt", S_SHAMT, 32'd3);

        // Reset during stall gives a bubble.
        stall = 1'b1; rst_n = 1'b0;
        tick();
        push("rst_stall_valid", S_VALID, 32'd0);
        push("rst_stall_ctrl",  S_CTRL,  32'd0);
        rst_n = 1'b1; stall = 1'b0;
        tick();
        driver_done = 1'b1;
    end

    // End of run: drain the scoreboard with a bound, then summarise.
    initial begin
        int guard;
        guard = 0;
        while (!driver_done && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        if (!driver_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL driver_timeout: got running, expected done");
        end
        repeat (3) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
